// File: rtl/mem_responder.sv
// Memory-side responder for the 2-bit serial CPU link: deserializes command frames,
// executes byte/word accesses on an internal RAM and serializes read replies.
module mem_responder #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int MEM_BYTES      = 256,
  parameter int REPLY_DELAY    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NSHIFT-1:0]            tx_pins,
  output logic [NSHIFT-1:0]            rx_pins,
  output logic                         busy,
  output logic                         proto_error,
  input  logic                         dbg_we,
  input  logic [$clog2(MEM_BYTES)-1:0] dbg_addr,
  input  logic [7:0]                   dbg_wdata,
  output logic [7:0]                   dbg_rdata
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [3:0] PAY_LAST = 4'(PAYLOAD_CYCLES - 1);
  localparam logic [3:0] DLY_LAST = 4'((REPLY_DELAY > 0) ? (REPLY_DELAY - 1) : 0);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, EXEC, DELAY, RSTART, RDATA
  } state_t;

  state_t              state, state_n;
  logic [1:0]          cmd, cmd_n;
  logic [15:0]         addr, addr_n;
  logic [15:0]         data, data_n;
  logic [15:0]         reply, reply_n;
  logic [3:0]          cnt, cnt_n;
  logic [NSHIFT-1:0]   rx_n;
  logic                perr_n;
  logic                wr_lo, wr_hi;
  logic [AW-1:0]       a_lo, a_hi;
  logic [7:0]          mem [MEM_BYTES];

  // Only the low address bits select a byte; the high-byte address wraps in the RAM.
  assign a_lo      = addr[AW-1:0];
  assign a_hi      = a_lo + AW'(1);
  assign busy      = (state != IDLE);
  assign dbg_rdata = mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd         <= '0;
      addr        <= '0;
      data        <= '0;
      reply       <= '0;
      cnt         <= '0;
      rx_pins     <= '0;
      proto_error <= 1'b0;
    end else begin
      state       <= state_n;
      cmd         <= cmd_n;
      addr        <= addr_n;
      data        <= data_n;
      reply       <= reply_n;
      cnt         <= cnt_n;
      rx_pins     <= rx_n;
      proto_error <= perr_n;
    end
  end

  // rx_pins is registered, so its value is chosen from the state being entered.
  always_comb begin
    state_n = state;
    cmd_n   = cmd;
    addr_n  = addr;
    data_n  = data;
    reply_n = reply;
    cnt_n   = cnt;
    rx_n    = '0;
    perr_n  = proto_error;
    wr_lo   = 1'b0;
    wr_hi   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_pins == 2'b01) state_n = CMD;
        else if (tx_pins[1]) perr_n = 1'b1;
      end
      CMD: begin
        cmd_n   = tx_pins;
        cnt_n   = '0;
        state_n = ADDR;
      end
      ADDR: begin
        addr_n = {tx_pins, addr[15:NSHIFT]};
        if (cnt == PAY_LAST) begin
          cnt_n   = '0;
          state_n = cmd[0] ? WDATA : EXEC;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      WDATA: begin
        data_n = {tx_pins, data[15:NSHIFT]};
        if (cnt == PAY_LAST) begin
          cnt_n   = '0;
          state_n = EXEC;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      EXEC: begin
        if (cmd[0]) begin
          wr_lo   = 1'b1;
          wr_hi   = ~cmd[1];
          state_n = IDLE;
        end else begin
          reply_n = {(cmd[1] ? 8'h00 : mem[a_hi]), mem[a_lo]};
          if (REPLY_DELAY == 0) begin
            state_n = RSTART;
            rx_n    = 2'b01;
          end else begin
            cnt_n   = '0;
            state_n = DELAY;
          end
        end
      end
      DELAY: begin
        if (cnt == DLY_LAST) begin
          cnt_n   = '0;
          state_n = RSTART;
          rx_n    = 2'b01;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RSTART: begin
        rx_n    = reply[NSHIFT-1:0];
        reply_n = {{NSHIFT{1'b0}}, reply[15:NSHIFT]};
        cnt_n   = '0;
        state_n = RDATA;
      end
      RDATA: begin
        if (cnt == PAY_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n   = cnt + 4'd1;
          rx_n    = reply[NSHIFT-1:0];
          reply_n = {{NSHIFT{1'b0}}, reply[15:NSHIFT]};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM is never cleared; a reset at the EXEC edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst_n && wr_lo) mem[a_lo] <= data[7:0];
    if (rst_n && wr_hi) mem[a_hi] <= data[15:8];
    if (dbg_we && !busy) mem[dbg_addr] <= dbg_wdata;
  end

endmodule
